// File: rtl/sprite_pop_ctrl.sv
// ----------------------------------------------------------------------------
// sprite_pop_ctrl
//
// Bouncing-sprite controller with a "pop" effect. The sprite moves diagonally
// across the active screen area and bounces off the edges. A trigger switches
// the sprite to its popped image for POP_FRAMES frames. A lockout of
// COOL_FRAMES frames follows, during which further triggers are ignored.
// Position, direction and image select change only at the start of vertical
// blanking, so no visible line is ever torn.
//
// Ports
//   pixel_clk  in   1   sole clock, all state changes on its rising edge
//   rst        in   1   synchronous active-high reset
//   h_count    in  11   current pixel column from the timing generator
//   v_count    in  10   current line from the timing generator
//   trigger    in   1   pop request (pulse or level), sampled every cycle
//   move_en    in   1   motion enable; 0 freezes position and direction
//   x          out 11   sprite left edge
//   y          out 10   sprite top edge
//   pop        out  1   1 selects the popped sprite image (state POP)
//   busy       out  1   1 while in POP or COOL
//   pop_count  out  8   pops started, saturating at 255
// ----------------------------------------------------------------------------
module sprite_pop_ctrl #(
   parameter int SCREEN_W    = 1280,
   parameter int SCREEN_H    = 720,
   parameter int SPRITE_W    = 256,
   parameter int SPRITE_H    = 128,
   parameter int STEP        = 2,
   parameter int POP_FRAMES  = 30,
   parameter int COOL_FRAMES = 15
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic [10:0] h_count,
   input  logic [9:0]  v_count,
   input  logic        trigger,
   input  logic        move_en,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic        pop,
   output logic        busy,
   output logic [7:0]  pop_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_POP  = 2'd1;
   localparam logic [1:0] S_COOL = 2'd2;

   // Frame counter wide enough for the longer of the two hold periods.
   localparam int MAX_FRAMES = (POP_FRAMES > COOL_FRAMES) ? POP_FRAMES : COOL_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES) + 1;

   // Boundary arithmetic runs one bit wider than x/y so x+STEP cannot wrap.
   localparam logic [11:0] XMAX_E = 12'(SCREEN_W - SPRITE_W);
   localparam logic [10:0] YMAX_E = 11'(SCREEN_H - SPRITE_H);
   localparam logic [11:0] STEP_X = 12'(STEP);
   localparam logic [10:0] STEP_Y = 11'(STEP);

   logic [1:0]       r_state;
   logic             r_pending;
   logic [CNT_W-1:0] r_frame_cnt;
   logic             r_pop;
   logic             r_busy;
   logic [7:0]       r_pop_count;
   logic [10:0]      r_x;
   logic [9:0]       r_y;
   logic             r_dir_left;   // 0 = moving right, 1 = moving left
   logic             r_dir_up;     // 0 = moving down,  1 = moving up

   logic             w_frame_tick;
   logic             w_start;
   logic             w_move;
   logic [11:0]      w_x_ext;
   logic [10:0]      w_y_ext;

   // First pixel of the first blanking line: exactly one cycle per frame.
   assign w_frame_tick = (h_count == 11'd0) && (v_count == 10'(SCREEN_H));

   // A trigger arriving on the tick itself starts the pop without waiting
   // for pending to be registered first.
   assign w_start = w_frame_tick && (r_state == S_IDLE) && (r_pending || trigger);

   // The sprite freezes while popped; it still moves on the tick that enters
   // POP and throughout COOL.
   assign w_move  = w_frame_tick && move_en && (r_state != S_POP);

   assign w_x_ext = {1'b0, r_x};
   assign w_y_ext = {1'b0, r_y};

   // ------------------------------------------------------------------------
   // Pop state machine. pop and busy are registered alongside the state so
   // they change on the same edge as the state transition.
   // ------------------------------------------------------------------------
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_pending   <= 1'b0;
         r_frame_cnt <= '0;
         r_pop       <= 1'b0;
         r_busy      <= 1'b0;
         r_pop_count <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state     <= S_POP;
                  r_pending   <= 1'b0;
                  r_frame_cnt <= CNT_W'(POP_FRAMES - 1);
                  r_pop       <= 1'b1;
                  r_busy      <= 1'b1;
                  if (r_pop_count != 8'hFF) begin
                     r_pop_count <= r_pop_count + 8'd1;
                  end
               end else if (trigger) begin
                  r_pending <= 1'b1;
               end
            end
            S_POP: begin
               if (w_frame_tick) begin
                  if (r_frame_cnt == '0) begin
                     r_state     <= S_COOL;
                     r_frame_cnt <= CNT_W'(COOL_FRAMES - 1);
                     r_pop       <= 1'b0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt - 1'b1;
                  end
               end
            end
            S_COOL: begin
               if (w_frame_tick) begin
                  if (r_frame_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_frame_cnt <= r_frame_cnt - 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_pop   <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Motion: clamp to the edge and reverse when the next step would reach or
   // cross it.
   // ------------------------------------------------------------------------
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         r_x        <= 11'd0;
         r_y        <= 10'd0;
         r_dir_left <= 1'b0;
         r_dir_up   <= 1'b0;
      end else if (w_move) begin
         if (!r_dir_left) begin
            if (w_x_ext + STEP_X >= XMAX_E) begin
               r_x        <= XMAX_E[10:0];
               r_dir_left <= 1'b1;
            end else begin
               r_x <= r_x + STEP_X[10:0];
            end
         end else begin
            if (w_x_ext <= STEP_X) begin
               r_x        <= 11'd0;
               r_dir_left <= 1'b0;
            end else begin
               r_x <= r_x - STEP_X[10:0];
            end
         end

         if (!r_dir_up) begin
            if (w_y_ext + STEP_Y >= YMAX_E) begin
               r_y      <= YMAX_E[9:0];
               r_dir_up <= 1'b1;
            end else begin
               r_y <= r_y + STEP_Y[9:0];
            end
         end else begin
            if (w_y_ext <= STEP_Y) begin
               r_y      <= 10'd0;
               r_dir_up <= 1'b0;
            end else begin
               r_y <= r_y - STEP_Y[9:0];
            end
         end
      end
   end

   assign x         = r_x;
   assign y         = r_y;
   assign pop       = r_pop;
   assign busy      = r_busy;
   assign pop_count = r_pop_count;

endmodule

// File: tb/tb_sprite_pop_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sprite_pop_ctrl
//
// Two instances share the clock and timing inputs: dut uses the default
// parameters, dut3 uses STEP=3 with short pop/cool periods so that 256 pop
// sequences run quickly. Each is held in reset while the other is exercised.
// Frames are compressed to two cycles: one ordinary cycle, then the
// frame_tick cycle (h_count=0, v_count=SCREEN_H).
// ----------------------------------------------------------------------------
module tb_sprite_pop_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst3;
   logic [10:0] h_count;
   logic [9:0]  v_count;
   logic        trigger;
   logic        move_en;

   logic [10:0] x,  x3;
   logic [9:0]  y,  y3;
   logic        pop, pop3;
   logic        busy, busy3;
   logic [7:0]  pop_count, pop_count3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sprite_pop_ctrl dut (
      .pixel_clk (clk),
      .rst       (rst),
      .h_count   (h_count),
      .v_count   (v_count),
      .trigger   (trigger),
      .move_en   (move_en),
      .x         (x),
      .y         (y),
      .pop       (pop),
      .busy      (busy),
      .pop_count (pop_count)
   );

   sprite_pop_ctrl #(
      .STEP        (3),
      .POP_FRAMES  (2),
      .COOL_FRAMES (1)
   ) dut3 (
      .pixel_clk (clk),
      .rst       (rst3),
      .h_count   (h_count),
      .v_count   (v_count),
      .trigger   (trigger),
      .move_en   (move_en),
      .x         (x3),
      .y         (y3),
      .pop       (pop3),
      .busy      (busy3),
      .pop_count (pop_count3)
   );

   typedef struct packed {
      logic        rst;
      logic        trig;
      logic        mv;
      logic        tick;
      logic [10:0] ex;
      logic [9:0]  ey;
      logic        epop;
      logic        ebusy;
      logic [7:0]  ecnt;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock cycle; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step(input bit tk);
      h_count = tk ? 11'd0 : 11'd100;
      v_count = tk ? 10'd720 : 10'd5;
      @(posedge clk);
      #1;
   endtask

   // Ordinary cycle followed by the frame_tick cycle.
   task automatic frame();
      step(1'b0);
      step(1'b1);
   endtask

   task automatic chk_dut(input string tag, input int ex, input int ey,
                          input int epop, input int ebusy, input int ecnt);
      chk({tag, ".x"}, int'(x), ex);
      chk({tag, ".y"}, int'(y), ey);
      chk({tag, ".pop"}, int'(pop), epop);
      chk({tag, ".busy"}, int'(busy), ebusy);
      chk({tag, ".pop_count"}, int'(pop_count), ecnt);
   endtask

   initial begin
      int ex;
      int ey;
      int ecnt;

      //            rst  trig mv   tick  x       y      pop  busy cnt
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 8'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'd2, 10'd2, 1'b0, 1'b0, 8'd0};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'd4, 10'd4, 1'b0, 1'b0, 8'd0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 11'd4, 10'd4, 1'b0, 1'b0, 8'd0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 11'd4, 10'd4, 1'b0, 1'b0, 8'd0};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'd6, 10'd6, 1'b1, 1'b1, 8'd1};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 11'd6, 10'd6, 1'b1, 1'b1, 8'd1};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 11'd6, 10'd6, 1'b1, 1'b1, 8'd1};
      vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 11'd6, 10'd6, 1'b1, 1'b1, 8'd1};

      rst = 1'b1; rst3 = 1'b1; trigger = 1'b0; move_en = 1'b0;
      h_count = 11'd100; v_count = 10'd5;
      step(1'b0);

      // ---- Table: reset, motion, mid-frame trigger, entry into POP ----
      for (int i = 0; i < 9; i++) begin
         rst     = vecs[i].rst;
         trigger = vecs[i].trig;
         move_en = vecs[i].mv;
         step(vecs[i].tick);
         chk_dut($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey),
                 int'(vecs[i].epop), int'(vecs[i].ebusy), int'(vecs[i].ecnt));
         $display("vec %0d: x=%0d y=%0d pop=%0d busy=%0d cnt=%0d",
                  i, x, y, pop, busy, pop_count);
      end
      trigger = 1'b0;
      move_en = 1'b1;

      // ---- Remaining POP ticks (T3..T29): frozen, triggers ignored ----
      for (int t = 3; t <= 29; t++) begin
         trigger = 1'b1; step(1'b0);
         trigger = 1'b0; step(1'b1);
         chk_dut($sformatf("pop_t%0d", t), 6, 6, 1, 1, 1);
      end
      $display("pop phase done: pop=%0d busy=%0d x=%0d", pop, busy, x);

      // ---- COOL ticks (T30..T44): moving again, triggers ignored ----
      for (int t = 30; t <= 44; t++) begin
         trigger = 1'b1; step(1'b0);
         trigger = 1'b0; step(1'b1);
         chk_dut($sformatf("cool_t%0d", t), 6 + 2 * (t - 30), 6 + 2 * (t - 30), 0, 1, 1);
      end
      $display("cool phase done: pop=%0d busy=%0d x=%0d", pop, busy, x);

      // ---- Back to IDLE, no second pop ----
      frame();
      chk_dut("idle_t45", 36, 36, 0, 0, 1);
      frame();
      chk_dut("idle_t46", 38, 38, 0, 0, 1);
      $display("idle: pop=%0d busy=%0d cnt=%0d", pop, busy, pop_count);

      // ---- Trigger on the tick cycle itself, then reset at 10th POP tick ----
      move_en = 1'b0;
      step(1'b0);
      trigger = 1'b1; step(1'b1); trigger = 1'b0;
      chk("same_tick.pop", int'(pop), 1);
      chk("same_tick.pop_count", int'(pop_count), 2);
      for (int t = 1; t <= 8; t++) frame();
      chk("pop_t9.pop", int'(pop), 1);
      step(1'b0);
      rst = 1'b1; step(1'b1);
      chk_dut("rst_in_pop", 0, 0, 0, 0, 0);
      $display("reset in pop: pop=%0d busy=%0d cnt=%0d", pop, busy, pop_count);
      rst = 1'b0;

      // ---- Pending trigger discarded by reset ----
      trigger = 1'b1; step(1'b0); trigger = 1'b0;
      rst = 1'b1; step(1'b0); rst = 1'b0;
      frame();
      chk("pending_cleared.pop", int'(pop), 0);
      chk("pending_cleared.busy", int'(busy), 0);
      $display("pending discard: pop=%0d busy=%0d", pop, busy);

      // ---- 520 frames of free motion, bounce at XMAX=1024 ----
      rst = 1'b1; step(1'b0); rst = 1'b0;
      move_en = 1'b1;
      for (int k = 1; k <= 520; k++) begin
         frame();
         ex = (k <= 512) ? 2 * k : 1024 - 2 * (k - 512);
         ey = (k <= 296) ? 2 * k : 592 - 2 * (k - 296);
         chk($sformatf("bounce_x_k%0d", k), int'(x), ex);
         chk($sformatf("bounce_y_k%0d", k), int'(y), ey);
      end
      $display("bounce run: x=%0d y=%0d", x, y);

      // ---- STEP=3 instance: clamp from 1023 and to 0 from 1 ----
      rst = 1'b1; rst3 = 1'b1; move_en = 1'b0; trigger = 1'b0;
      step(1'b0);
      rst3 = 1'b0;
      chk("s3_reset.x", int'(x3), 0);
      move_en = 1'b1;
      for (int k = 1; k <= 685; k++) begin
         frame();
         if (k == 341) chk("s3_x_k341", int'(x3), 1023);
         if (k == 342) chk("s3_x_k342", int'(x3), 1024);
         if (k == 343) chk("s3_x_k343", int'(x3), 1021);
         if (k == 683) chk("s3_x_k683", int'(x3), 1);
         if (k == 684) chk("s3_x_k684", int'(x3), 0);
         if (k == 685) chk("s3_x_k685", int'(x3), 3);
         if (k == 197) chk("s3_y_k197", int'(y3), 591);
         if (k == 198) chk("s3_y_k198", int'(y3), 592);
      end
      $display("step3 run: x=%0d y=%0d", x3, y3);

      // ---- 256 pop sequences with trigger held high: saturation ----
      move_en = 1'b0;
      trigger = 1'b1;
      for (int n = 1; n <= 256; n++) begin
         frame();
         ecnt = (n < 255) ? n : 255;
         chk($sformatf("sat_pop_n%0d", n), int'(pop3), 1);
         chk($sformatf("sat_cnt_n%0d", n), int'(pop_count3), ecnt);
         for (int t = 0; t < 3; t++) frame();
         chk($sformatf("sat_idle_n%0d", n), int'(busy3), 0);
      end
      trigger = 1'b0;
      $display("saturation: pop_count=%0d", pop_count3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
